// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter and instruction-fetch sequencer. Holds the architectural PC,
// presents it to an external PC+4 adder, issues one instruction-memory request
// at a time and hands each returned instruction, tagged with its PC, to decode
// over a valid/ready handshake. Branch/jump redirects override sequential flow
// in every state; a 1-bit kill flag marks an in-flight response as stale.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   pc_out            current PC, feeds the PC+4 adder SrcA
//   pc_plus4_in       adder result, combinational pc_out + 4
//   redirect_valid    take redirect_target this cycle
//   redirect_target   branch/jump target (bits [1:0] are ignored)
//   imem_req_valid    fetch request valid (registered)
//   imem_req_ready    memory accepts the request
//   imem_req_addr     fetch address, equal to pc_out
//   imem_rsp_valid    response valid
//   imem_rsp_data     fetched instruction word
//   inst_valid        instruction available to decode (registered)
//   inst_ready        decode accepts the instruction
//   inst_data         instruction word (registered)
//   inst_pc           PC of inst_data (registered)
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] pc_out,
    input  logic [WIDTH-1:0] pc_plus4_in,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst_data,
    output logic [WIDTH-1:0] inst_pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             kill_q, kill_d;
    logic             req_valid_q, req_valid_d;
    logic             inst_valid_q, inst_valid_d;
    logic [WIDTH-1:0] inst_data_q, inst_data_d;
    logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic [WIDTH-1:0] redirect_pc;

    // Redirect targets are word aligned by clearing the two low bits.
    assign redirect_pc = redirect_target & ~{{(WIDTH-2){1'b0}}, 2'b11};

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
            end

            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    // An accepted request for the old PC is now in flight;
                    // its response must be thrown away.
                    if (imem_req_ready) begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_rsp_valid) begin
                        // Response lands together with the redirect: drop it
                        // here, so nothing stale remains outstanding.
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_data_d  = imem_rsp_data;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_plus4_in;
                        state_d      = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                // With a redirect, a simultaneous inst_ready still completes
                // the transfer; either way the held instruction is retired.
                if (redirect_valid) begin
                    pc_d         = redirect_pc;
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Request valid is registered: it is high exactly while in REQ.
        req_valid_d = (state_d == S_REQ);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= {WIDTH{1'b0}};
            inst_pc_q    <= {WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign pc_out         = pc_q;
    assign imem_req_addr  = pc_q;
    assign imem_req_valid = req_valid_q;
    assign inst_valid     = inst_valid_q;
    assign inst_data      = inst_data_q;
    assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed bench for pc_fetch_unit. A small memory model answers each accepted
// request after mem_lat cycles with a word derived from its address; the PC+4
// adder is modelled with a continuous add. Expected instruction PCs are pushed
// to a queue as each step is set up and popped whenever decode accepts an
// instruction, comparing both inst_pc and inst_data.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    int          n_acc  = 0;
    int          mem_cnt = 0;
    int          mem_lat = 1;
    int          acc_base;
    logic [31:0] mem_addr;
    logic [31:0] exp_q[$];

    pc_fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_out          (pc_out),
        .pc_plus4_in     (pc_plus4_in),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    // PC+4 adder in front of the fetch unit.
    assign pc_plus4_in = pc_out + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Handshakes are sampled just before the edge, the memory
    // model updates its response one time unit after the edge.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        logic [31:0] e;
        acc = rst_n && imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        if (rst_n && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_inst", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e);
                check("inst_data", inst_data, mem_word(e));
            end
            pops++;
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (acc) begin
            n_acc++;
            mem_addr = a;
            mem_cnt  = mem_lat;
        end else if (mem_cnt > 1) begin
            mem_cnt--;
        end
        if (mem_cnt == 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr);
            mem_cnt        = 0;
        end
    endtask

    task automatic run_until_pops(input int n, input int budget);
        int target;
        int cyc;
        target = pops + n;
        cyc    = 0;
        while (pops < target && cyc < budget) begin
            tick();
            cyc++;
        end
        check("pop_timeout", 32'(pops), 32'(target));
    endtask

    task automatic wait_valid(input int budget);
        int cyc;
        cyc = 0;
        while (!inst_valid && cyc < budget) begin
            tick();
            cyc++;
        end
        check("valid_timeout", {31'b0, inst_valid}, 32'd1);
    endtask

    // Reset, release, and step out of IDLE into REQ.
    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        mem_cnt        = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        inst_ready      = 1'b1;

        // Reset values and first sequential fetches.
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        rst_n = 1'b1;
        tick();
        check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        run_until_pops(3, 40);

        // Backpressure on both sides.
        do_reset();
        exp_q.push_back(32'h0);
        run_until_pops(1, 20);
        imem_req_ready = 1'b0;
        acc_base       = n_acc;
        repeat (3) begin
            tick();
            check("bp_req_addr", imem_req_addr, 32'h4);
            check("bp_req_valid", {31'b0, imem_req_valid}, 32'd1);
        end
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        exp_q.push_back(32'h4);
        tick();
        tick();
        check("bp_hold_valid", {31'b0, inst_valid}, 32'd1);
        repeat (5) begin
            tick();
            check("bp_inst_valid", {31'b0, inst_valid}, 32'd1);
            check("bp_inst_pc", inst_pc, 32'h4);
            check("bp_inst_data", inst_data, mem_word(32'h4));
            check("bp_no_req", {31'b0, imem_req_valid}, 32'd0);
        end
        check("bp_single_req", 32'(n_acc - acc_base), 32'd1);
        inst_ready = 1'b1;
        tick();
        check("bp_consumed", 32'(exp_q.size()), 32'd0);

        // Redirect while waiting for a slow response: that response is killed.
        do_reset();
        mem_lat = 2;
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        tick();
        redirect_valid  = 1'b0;
        check("wr_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("wr_pc_out", pc_out, 32'h100);
        tick();
        check("wr_discard_valid", {31'b0, inst_valid}, 32'd0);
        check("wr_new_addr", imem_req_addr, 32'h100);
        check("wr_new_req_valid", {31'b0, imem_req_valid}, 32'd1);
        exp_q.push_back(32'h100);
        run_until_pops(1, 20);

        // Redirect in HOLD with inst_ready, then redirect alongside a response.
        mem_lat    = 1;
        inst_ready = 1'b0;
        exp_q.push_back(32'h104);
        wait_valid(20);
        inst_ready      = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0203;
        tick();
        redirect_valid  = 1'b0;
        check("hr_consumed", 32'(exp_q.size()), 32'd0);
        check("hr_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("hr_req_addr", imem_req_addr, 32'h200);
        check("hr_req_valid", {31'b0, imem_req_valid}, 32'd1);
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0300;
        tick();
        redirect_valid  = 1'b0;
        check("rr_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rr_req_addr", imem_req_addr, 32'h300);
        check("rr_req_valid", {31'b0, imem_req_valid}, 32'd1);
        exp_q.push_back(32'h300);
        run_until_pops(1, 20);

        // Redirect on an accepted request, then PC wrap-around.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid  = 1'b0;
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        check("wrap_req_valid", {31'b0, imem_req_valid}, 32'd0);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        run_until_pops(2, 30);
        check("wrap_next_addr", imem_req_addr, 32'h4);

        // Asynchronous reset in WAIT, stray response during IDLE ignored.
        mem_lat    = 3;
        inst_ready = 1'b0;
        tick();
        check("mr_in_wait", {31'b0, imem_req_valid}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        mem_cnt = 0;
        check("mr_pc_out", pc_out, 32'h0);
        check("mr_req_addr", imem_req_addr, 32'h0);
        check("mr_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("mr_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("mr_inst_data", inst_data, 32'h0);
        check("mr_inst_pc", inst_pc, 32'h0);
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        tick();
        check("mr_restart_valid", {31'b0, imem_req_valid}, 32'd1);
        check("mr_restart_addr", imem_req_addr, 32'h0);
        check("mr_no_stray_inst", {31'b0, inst_valid}, 32'd0);
        mem_lat    = 1;
        inst_ready = 1'b1;
        exp_q.push_back(32'h0);
        run_until_pops(1, 20);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
